// File: rtl/bp_common_pkg.sv
// -----------------------------------------------------------------------------
// bp_common_pkg
//   Shared types and width helpers for the dcache LCE command path.
//   - CCE->LCE command types, coherence states, LCE->CCE ack types
//   - lce_cmd_state_e: state encoding of the LCE command handler FSM
//   - default configuration and width localparams derived from it
//   - helper functions that derive the dcache address slicing from the
//     cache geometry, so modules and interfaces stay consistent
// -----------------------------------------------------------------------------
package bp_common_pkg;

    // Default configuration of the dcache / coherence system.
    localparam int paddr_width_gp = 22;
    localparam int num_cce_gp     = 2;
    localparam int num_lce_gp     = 2;
    localparam int ways_gp        = 8;
    localparam int sets_gp        = 64;
    localparam int data_width_gp  = 64;

    // Id/select width that stays at least one bit for single-entry spaces.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // A dcache block holds ways_p words of data_width_p bits, so the block
    // offset covers the word select plus the byte-in-word select.
    function automatic int block_offset_width(input int ways, input int data_width);
        return $clog2(ways) + $clog2(data_width / 8);
    endfunction

    function automatic int index_width(input int sets);
        return id_width(sets);
    endfunction

    // The set index sits directly above the block offset; the rest of the
    // physical address above the page offset is the tag.
    function automatic int page_offset_width(input int ways, input int data_width, input int sets);
        return block_offset_width(ways, data_width) + index_width(sets);
    endfunction

    function automatic int ptag_width(input int paddr_width, input int ways,
                                      input int data_width, input int sets);
        return paddr_width - page_offset_width(ways, data_width, sets);
    endfunction

    // Widths for the default configuration.
    localparam int lce_id_width_gp = id_width(num_lce_gp);
    localparam int cce_id_width_gp = id_width(num_cce_gp);
    localparam int way_id_width_gp = id_width(ways_gp);
    localparam int index_width_gp  = index_width(sets_gp);
    localparam int ptag_width_gp   = ptag_width(paddr_width_gp, ways_gp, data_width_gp, sets_gp);

    typedef enum logic [3:0] {
        e_lce_cmd_sync           = 4'd0,
        e_lce_cmd_set_clear      = 4'd1,
        e_lce_cmd_transfer       = 4'd2,
        e_lce_cmd_writeback      = 4'd3,
        e_lce_cmd_set_tag        = 4'd4,
        e_lce_cmd_set_tag_wakeup = 4'd5,
        e_lce_cmd_invalidate_tag = 4'd6
    } bp_cce_lce_cmd_type_e;

    typedef enum logic [1:0] {
        e_COH_I = 2'd0,
        e_COH_S = 2'd1,
        e_COH_E = 2'd2,
        e_COH_M = 2'd3
    } bp_coh_states_e;

    typedef enum logic [1:0] {
        e_lce_cce_sync_ack = 2'd0,
        e_lce_cce_inv_ack  = 2'd1,
        e_lce_cce_coh_ack  = 2'd2
    } bp_lce_cce_ack_type_e;

    typedef enum logic [2:0] {
        e_lce_cmd_reset,
        e_lce_cmd_ready,
        e_lce_cmd_sync_ack,
        e_lce_cmd_tag_write,
        e_lce_cmd_inv_ack
    } lce_cmd_state_e;

endpackage

// File: rtl/bp_be_dcache_lce_cmd_if.sv
// -----------------------------------------------------------------------------
// bp_be_dcache_lce_cmd_if
//   Bundles the three channels the LCE command handler talks on:
//   - command channel   (CCE -> handler, valid/ready)
//   - tag memory write  (handler -> tag mem, valid/yumi) plus the
//                        tag_set / tag_set_wakeup pulses to the request handler
//   - response channel  (handler -> CCE, valid/yumi)
//   Modports:
//   - slave  : the command handler
//   - master : the environment (CCE, tag memory, response arbiter)
// -----------------------------------------------------------------------------
interface bp_be_dcache_lce_cmd_if
    import bp_common_pkg::*;
#(
    parameter int paddr_width_p = paddr_width_gp,
    parameter int num_cce_p     = num_cce_gp,
    parameter int num_lce_p     = num_lce_gp,
    parameter int ways_p        = ways_gp,
    parameter int sets_p        = sets_gp,
    parameter int data_width_p  = data_width_gp
);

    localparam int cce_id_width_lp = id_width(num_cce_p);
    localparam int lce_id_width_lp = id_width(num_lce_p);
    localparam int way_id_width_lp = id_width(ways_p);
    localparam int index_width_lp  = index_width(sets_p);
    localparam int ptag_width_lp   = ptag_width(paddr_width_p, ways_p, data_width_p, sets_p);

    // Command channel
    logic                       lce_cmd_v_i;
    logic                       lce_cmd_ready_o;
    bp_cce_lce_cmd_type_e       lce_cmd_type_i;
    logic [cce_id_width_lp-1:0] lce_cmd_src_id_i;
    logic [paddr_width_p-1:0]   lce_cmd_addr_i;
    logic [way_id_width_lp-1:0] lce_cmd_way_i;
    bp_coh_states_e             lce_cmd_state_i;

    // Tag memory write and request-handler notification
    logic                       tag_mem_v_o;
    logic                       tag_mem_yumi_i;
    logic [index_width_lp-1:0]  tag_mem_index_o;
    logic [way_id_width_lp-1:0] tag_mem_way_o;
    logic [ptag_width_lp-1:0]   tag_mem_tag_o;
    bp_coh_states_e             tag_mem_state_o;
    logic                       tag_set_o;
    logic                       tag_set_wakeup_o;

    // Response channel
    logic                       lce_resp_v_o;
    logic                       lce_resp_yumi_i;
    bp_lce_cce_ack_type_e       lce_resp_msg_type_o;
    logic [cce_id_width_lp-1:0] lce_resp_dst_id_o;
    logic [lce_id_width_lp-1:0] lce_resp_src_id_o;
    logic [paddr_width_p-1:0]   lce_resp_addr_o;

    modport slave (
        input  lce_cmd_v_i, lce_cmd_type_i, lce_cmd_src_id_i, lce_cmd_addr_i,
               lce_cmd_way_i, lce_cmd_state_i, tag_mem_yumi_i, lce_resp_yumi_i,
        output lce_cmd_ready_o, tag_mem_v_o, tag_mem_index_o, tag_mem_way_o,
               tag_mem_tag_o, tag_mem_state_o, tag_set_o, tag_set_wakeup_o,
               lce_resp_v_o, lce_resp_msg_type_o, lce_resp_dst_id_o,
               lce_resp_src_id_o, lce_resp_addr_o
    );

    modport master (
        output lce_cmd_v_i, lce_cmd_type_i, lce_cmd_src_id_i, lce_cmd_addr_i,
               lce_cmd_way_i, lce_cmd_state_i, tag_mem_yumi_i, lce_resp_yumi_i,
        input  lce_cmd_ready_o, tag_mem_v_o, tag_mem_index_o, tag_mem_way_o,
               tag_mem_tag_o, tag_mem_state_o, tag_set_o, tag_set_wakeup_o,
               lce_resp_v_o, lce_resp_msg_type_o, lce_resp_dst_id_o,
               lce_resp_src_id_o, lce_resp_addr_o
    );

endinterface

// File: rtl/bp_be_dcache_lce_cmd.sv
// -----------------------------------------------------------------------------
// bp_be_dcache_lce_cmd
//   LCE command handler for the dcache. Consumes CCE->LCE commands (sync,
//   set_tag, set_tag_wakeup, invalidate_tag), writes tag + coherence state
//   into the tag memory, pulses tag_set / tag_set_wakeup to the waiting
//   request handler and returns sync_ack / inv_ack on the response channel.
//
//   Ports:
//   - clk_i       clock
//   - reset_n_i   asynchronous active-low reset; deassertion is expected to
//                 be synchronised to clk_i upstream
//   - lce_id_i    own LCE id, used as response src_id
//   - bus         slave side of bp_be_dcache_lce_cmd_if (command, tag memory
//                 and response channels)
//   - lce_ready_o high once num_cce_p syncs have been acked; sticky
//   - cmd_error_o one-cycle pulse the cycle after an unsupported command
//                 type was consumed
// -----------------------------------------------------------------------------
module bp_be_dcache_lce_cmd
    import bp_common_pkg::*;
#(
    parameter int paddr_width_p = paddr_width_gp,
    parameter int num_cce_p     = num_cce_gp,
    parameter int num_lce_p     = num_lce_gp,
    parameter int ways_p        = ways_gp,
    parameter int sets_p        = sets_gp,
    parameter int data_width_p  = data_width_gp
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [id_width(num_lce_p)-1:0] lce_id_i,
    bp_be_dcache_lce_cmd_if.slave          bus,
    output logic                           lce_ready_o,
    output logic                           cmd_error_o
);

    localparam int cce_id_width_lp     = id_width(num_cce_p);
    localparam int way_id_width_lp     = id_width(ways_p);
    localparam int index_width_lp      = index_width(sets_p);
    localparam int block_offset_lp     = block_offset_width(ways_p, data_width_p);
    localparam int ptag_width_lp       = ptag_width(paddr_width_p, ways_p, data_width_p, sets_p);
    localparam int sync_cnt_width_lp   = $clog2(num_cce_p + 1);
    localparam logic [sync_cnt_width_lp-1:0] sync_target_lp = sync_cnt_width_lp'(num_cce_p);

    lce_cmd_state_e state_q, state_d;

    // Latched command
    bp_cce_lce_cmd_type_e       cmd_type_q;
    logic [cce_id_width_lp-1:0] cmd_src_q;
    logic [paddr_width_p-1:0]   cmd_addr_q;
    logic [way_id_width_lp-1:0] cmd_way_q;
    bp_coh_states_e             cmd_state_q;

    logic [sync_cnt_width_lp-1:0] sync_count_q, sync_count_inc;
    logic lce_ready_q;
    logic cmd_error_q, cmd_error_d;
    logic cmd_ready, cmd_fire, sync_ack_done, set_lce_ready;

    assign cmd_fire = bus.lce_cmd_v_i & cmd_ready;

    // Saturating increment: extra syncs after boot never wrap the count.
    assign sync_count_inc = (sync_count_q == sync_target_lp)
                          ? sync_count_q
                          : sync_count_q + 1'b1;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        cmd_ready     = 1'b0;
        cmd_error_d   = 1'b0;
        sync_ack_done = 1'b0;
        set_lce_ready = 1'b0;
        bus.tag_mem_v_o         = 1'b0;
        bus.tag_set_o           = 1'b0;
        bus.tag_set_wakeup_o    = 1'b0;
        bus.lce_resp_v_o        = 1'b0;
        bus.lce_resp_msg_type_o = e_lce_cce_sync_ack;

        unique case (state_q)
            e_lce_cmd_reset: begin
                // Only syncs make progress before the LCE is ready.
                cmd_ready = 1'b1;
                if (bus.lce_cmd_v_i) begin
                    if (bus.lce_cmd_type_i == e_lce_cmd_sync) begin
                        state_d = e_lce_cmd_sync_ack;
                    end else begin
                        cmd_error_d = 1'b1;
                    end
                end
            end

            e_lce_cmd_ready: begin
                cmd_ready = 1'b1;
                if (bus.lce_cmd_v_i) begin
                    unique case (bus.lce_cmd_type_i)
                        e_lce_cmd_sync:           state_d = e_lce_cmd_sync_ack;
                        e_lce_cmd_set_tag,
                        e_lce_cmd_set_tag_wakeup,
                        e_lce_cmd_invalidate_tag: state_d = e_lce_cmd_tag_write;
                        default:                  cmd_error_d = 1'b1;
                    endcase
                end
            end

            e_lce_cmd_sync_ack: begin
                bus.lce_resp_v_o        = 1'b1;
                bus.lce_resp_msg_type_o = e_lce_cce_sync_ack;
                if (bus.lce_resp_yumi_i) begin
                    sync_ack_done = 1'b1;
                    // A sync after boot returns to ready without touching
                    // lce_ready; at boot the last CCE's sync flips it.
                    if (lce_ready_q || (sync_count_inc == sync_target_lp)) begin
                        set_lce_ready = 1'b1;
                        state_d       = e_lce_cmd_ready;
                    end else begin
                        state_d       = e_lce_cmd_reset;
                    end
                end
            end

            e_lce_cmd_tag_write: begin
                bus.tag_mem_v_o = 1'b1;
                if (bus.tag_mem_yumi_i) begin
                    unique case (cmd_type_q)
                        e_lce_cmd_set_tag: begin
                            bus.tag_set_o = 1'b1;
                            state_d       = e_lce_cmd_ready;
                        end
                        e_lce_cmd_set_tag_wakeup: begin
                            bus.tag_set_wakeup_o = 1'b1;
                            state_d              = e_lce_cmd_ready;
                        end
                        e_lce_cmd_invalidate_tag: state_d = e_lce_cmd_inv_ack;
                        default:                  state_d = e_lce_cmd_ready;
                    endcase
                end
            end

            e_lce_cmd_inv_ack: begin
                bus.lce_resp_v_o        = 1'b1;
                bus.lce_resp_msg_type_o = e_lce_cce_inv_ack;
                if (bus.lce_resp_yumi_i) begin
                    state_d = e_lce_cmd_ready;
                end
            end

            default: state_d = e_lce_cmd_reset;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= e_lce_cmd_reset;
            sync_count_q <= '0;
            lce_ready_q  <= 1'b0;
            cmd_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_error_q <= cmd_error_d;
            if (sync_ack_done) begin
                sync_count_q <= sync_count_inc;
            end
            if (set_lce_ready) begin
                lce_ready_q <= 1'b1;
            end
        end
    end

    // NOTE: the command register carries data only; it is qualified by the
    // FSM state, so it has no reset and loads solely on an accepted command.
    always_ff @(posedge clk_i) begin
        if (cmd_fire) begin
            cmd_type_q  <= bus.lce_cmd_type_i;
            cmd_src_q   <= bus.lce_cmd_src_id_i;
            cmd_addr_q  <= bus.lce_cmd_addr_i;
            cmd_way_q   <= bus.lce_cmd_way_i;
            cmd_state_q <= bus.lce_cmd_state_i;
        end
    end

    // Payloads come straight from the command register, so they hold
    // steady for as long as the matching valid waits for its yumi.
    assign bus.lce_cmd_ready_o   = cmd_ready;
    assign bus.tag_mem_index_o   = cmd_addr_q[block_offset_lp +: index_width_lp];
    assign bus.tag_mem_tag_o     = cmd_addr_q[paddr_width_p-1 -: ptag_width_lp];
    assign bus.tag_mem_way_o     = cmd_way_q;
    assign bus.tag_mem_state_o   = (cmd_type_q == e_lce_cmd_invalidate_tag) ? e_COH_I : cmd_state_q;
    assign bus.lce_resp_dst_id_o = cmd_src_q;
    assign bus.lce_resp_src_id_o = lce_id_i;
    assign bus.lce_resp_addr_o   = cmd_addr_q;

    assign lce_ready_o = lce_ready_q;
    assign cmd_error_o = cmd_error_q;

    // Handshake sanity: consumers only take what is offered.
    a_resp_yumi_needs_v: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) bus.lce_resp_yumi_i |-> bus.lce_resp_v_o);
    a_tag_yumi_needs_v: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) bus.tag_mem_yumi_i |-> bus.tag_mem_v_o);

endmodule

// File: tb/tb_bp_be_dcache_lce_cmd.sv
// -----------------------------------------------------------------------------
// tb_bp_be_dcache_lce_cmd
//   Directed bench for bp_be_dcache_lce_cmd with num_cce_p=2, ways=8,
//   sets=64, 64-bit words, 22-bit paddr (index = addr[11:6], tag = addr[21:12]).
//   Inputs change on the falling edge; outputs are sampled 1ns later.
// -----------------------------------------------------------------------------
module tb_bp_be_dcache_lce_cmd;
    import bp_common_pkg::*;

    logic       clk_i = 1'b0;
    logic       reset_n_i = 1'b0;
    logic [0:0] lce_id_i = 1'b1;
    logic       lce_ready_o;
    logic       cmd_error_o;

    int n_tests = 0;
    int n_fail  = 0;
    int ts_cnt  = 0;
    int tw_cnt  = 0;
    int both_cnt = 0;

    always #5 clk_i = ~clk_i;

    bp_be_dcache_lce_cmd_if #(
        .paddr_width_p(22), .num_cce_p(2), .num_lce_p(2),
        .ways_p(8), .sets_p(64), .data_width_p(64)
    ) bus ();

    bp_be_dcache_lce_cmd #(
        .paddr_width_p(22), .num_cce_p(2), .num_lce_p(2),
        .ways_p(8), .sets_p(64), .data_width_p(64)
    ) dut (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .lce_id_i   (lce_id_i),
        .bus        (bus),
        .lce_ready_o(lce_ready_o),
        .cmd_error_o(cmd_error_o)
    );

    // Pulse monitors, sampled at the active edge where the values are settled.
    always @(posedge clk_i) begin
        if (bus.tag_set_o) ts_cnt++;
        if (bus.tag_set_wakeup_o) tw_cnt++;
        if (bus.tag_set_o && bus.tag_set_wakeup_o) both_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        bus.lce_cmd_v_i      = 1'b0;
        bus.lce_cmd_type_i   = e_lce_cmd_sync;
        bus.lce_cmd_src_id_i = '0;
        bus.lce_cmd_addr_i   = '0;
        bus.lce_cmd_way_i    = '0;
        bus.lce_cmd_state_i  = e_COH_I;
        bus.tag_mem_yumi_i   = 1'b0;
        bus.lce_resp_yumi_i  = 1'b0;
    endtask

    // Present one command for a single cycle; it must be accepted.
    task automatic issue(input bp_cce_lce_cmd_type_e t, input logic [0:0] src,
                         input logic [21:0] addr, input logic [2:0] way,
                         input bp_coh_states_e st);
        step();
        bus.lce_cmd_v_i      = 1'b1;
        bus.lce_cmd_type_i   = t;
        bus.lce_cmd_src_id_i = src;
        bus.lce_cmd_addr_i   = addr;
        bus.lce_cmd_way_i    = way;
        bus.lce_cmd_state_i  = st;
        #1;
        check("cmd_ready_on_issue", bus.lce_cmd_ready_o, 1'b1);
        step();
        bus.lce_cmd_v_i = 1'b0;
        #1;
    endtask

    // Sync from src; response yumi'd after three waiting cycles.
    task automatic do_sync(input logic [0:0] src, input logic exp_ready_after);
        issue(e_lce_cmd_sync, src, 22'h0, 3'd0, e_COH_I);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            bus.lce_resp_yumi_i = (i == 3);
            #1;
            check("sync_resp_v", bus.lce_resp_v_o, 1'b1);
            check("sync_resp_msg", bus.lce_resp_msg_type_o, e_lce_cce_sync_ack);
            check("sync_resp_dst", bus.lce_resp_dst_id_o, src);
            check("sync_resp_src", bus.lce_resp_src_id_o, 1'b1);
            check("sync_cmd_busy", bus.lce_cmd_ready_o, 1'b0);
        end
        step();
        bus.lce_resp_yumi_i = 1'b0;
        #1;
        check("sync_resp_drop", bus.lce_resp_v_o, 1'b0);
        check("lce_ready_after_sync", lce_ready_o, exp_ready_after);
    endtask

    initial begin
        int ts0, tw0;
        idle_inputs();
        step();
        step();
        #1;
        check("rst_lce_ready", lce_ready_o, 1'b0);
        check("rst_tag_mem_v", bus.tag_mem_v_o, 1'b0);
        check("rst_resp_v", bus.lce_resp_v_o, 1'b0);
        check("rst_cmd_error", cmd_error_o, 1'b0);
        check("rst_cmd_ready", bus.lce_cmd_ready_o, 1'b1);
        step();
        reset_n_i = 1'b1;

        // Boot: two syncs, lce_ready rises only after the second ack.
        do_sync(1'b0, 1'b0);
        check("ready_state_before_2nd", bus.lce_cmd_ready_o, 1'b1);
        do_sync(1'b1, 1'b1);
        check("cmd_ready_after_boot", bus.lce_cmd_ready_o, 1'b1);

        // set_tag, tag memory stalls four cycles then takes it.
        ts0 = ts_cnt;
        issue(e_lce_cmd_set_tag, 1'b0, 22'h8040, 3'd3, e_COH_E);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            bus.tag_mem_yumi_i = (i == 4);
            #1;
            check("st_tag_mem_v", bus.tag_mem_v_o, 1'b1);
            check("st_index", bus.tag_mem_index_o, 6'd1);
            check("st_tag", bus.tag_mem_tag_o, 10'h008);
            check("st_way", bus.tag_mem_way_o, 3'd3);
            check("st_state", bus.tag_mem_state_o, e_COH_E);
            check("st_tag_set", bus.tag_set_o, (i == 4));
        end
        step();
        bus.tag_mem_yumi_i = 1'b0;
        #1;
        check("st_tag_mem_v_drop", bus.tag_mem_v_o, 1'b0);
        check("st_tag_set_count", ts_cnt - ts0, 1);
        check("st_back_to_ready", bus.lce_cmd_ready_o, 1'b1);

        // invalidate_tag: immediate tag yumi, inv_ack stalled six cycles.
        issue(e_lce_cmd_invalidate_tag, 1'b1, 22'h1000, 3'd1, e_COH_M);
        bus.tag_mem_yumi_i = 1'b1;
        #1;
        check("inv_tag_mem_v", bus.tag_mem_v_o, 1'b1);
        check("inv_state_I", bus.tag_mem_state_o, e_COH_I);
        check("inv_index", bus.tag_mem_index_o, 6'd0);
        check("inv_tag", bus.tag_mem_tag_o, 10'h001);
        check("inv_way", bus.tag_mem_way_o, 3'd1);
        check("inv_no_tag_set", bus.tag_set_o, 1'b0);
        step();
        bus.tag_mem_yumi_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            bus.lce_resp_yumi_i = (i == 6);
            #1;
            check("inv_resp_v", bus.lce_resp_v_o, 1'b1);
            check("inv_resp_msg", bus.lce_resp_msg_type_o, e_lce_cce_inv_ack);
            check("inv_resp_addr", bus.lce_resp_addr_o, 22'h1000);
            check("inv_resp_dst", bus.lce_resp_dst_id_o, 1'b1);
            check("inv_cmd_busy", bus.lce_cmd_ready_o, 1'b0);
        end
        step();
        bus.lce_resp_yumi_i = 1'b0;
        #1;
        check("inv_resp_drop", bus.lce_resp_v_o, 1'b0);
        check("inv_back_to_ready", bus.lce_cmd_ready_o, 1'b1);

        // Post-boot sync: acked, lce_ready stays, returns to ready state.
        do_sync(1'b0, 1'b1);

        // Unsupported type in ready: consumed, error pulse, stays ready.
        issue(e_lce_cmd_transfer, 1'b0, 22'h0, 3'd0, e_COH_I);
        check("rdy_cmd_error", cmd_error_o, 1'b1);
        check("rdy_err_still_ready", bus.lce_cmd_ready_o, 1'b1);
        check("rdy_err_no_tag_v", bus.tag_mem_v_o, 1'b0);
        step();
        #1;
        check("rdy_cmd_error_pulse", cmd_error_o, 1'b0);

        // set_tag_wakeup with a set_tag waiting right behind it.
        ts0 = ts_cnt;
        tw0 = tw_cnt;
        issue(e_lce_cmd_set_tag_wakeup, 1'b0, 22'h3F0C0, 3'd2, e_COH_S);
        bus.lce_cmd_v_i      = 1'b1;
        bus.lce_cmd_type_i   = e_lce_cmd_set_tag;
        bus.lce_cmd_addr_i   = 22'h25140;
        bus.lce_cmd_way_i    = 3'd5;
        bus.lce_cmd_state_i  = e_COH_M;
        bus.tag_mem_yumi_i   = 1'b1;
        #1;
        check("wk_index", bus.tag_mem_index_o, 6'd3);
        check("wk_tag", bus.tag_mem_tag_o, 10'h03F);
        check("wk_state", bus.tag_mem_state_o, e_COH_S);
        check("wk_wakeup_pulse", bus.tag_set_wakeup_o, 1'b1);
        check("wk_no_tag_set", bus.tag_set_o, 1'b0);
        check("wk_busy", bus.lce_cmd_ready_o, 1'b0);
        step();
        bus.tag_mem_yumi_i = 1'b0;
        #1;
        check("wk_wakeup_drop", bus.tag_set_wakeup_o, 1'b0);
        check("wk_second_accept", bus.lce_cmd_ready_o, 1'b1);
        step();
        bus.lce_cmd_v_i = 1'b0;
        #1;
        check("wk_second_tag_v", bus.tag_mem_v_o, 1'b1);
        check("wk_second_tag", bus.tag_mem_tag_o, 10'h025);
        check("wk_second_index", bus.tag_mem_index_o, 6'd5);
        check("wk_wakeup_count", tw_cnt - tw0, 1);
        check("wk_tag_set_count", ts_cnt - ts0, 0);

        // Reset while the second set_tag waits in tag-write.
        ts0 = ts_cnt;
        step();
        reset_n_i = 1'b0;
        #1;
        check("mid_rst_tag_v", bus.tag_mem_v_o, 1'b0);
        check("mid_rst_lce_ready", lce_ready_o, 1'b0);
        check("mid_rst_resp_v", bus.lce_resp_v_o, 1'b0);
        step();
        reset_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            check("post_rst_tag_v", bus.tag_mem_v_o, 1'b0);
            check("post_rst_lce_ready", lce_ready_o, 1'b0);
        end
        check("post_rst_no_tag_set", ts_cnt - ts0, 0);

        // set_tag before any sync is an error and leaves the LCE in reset.
        issue(e_lce_cmd_set_tag, 1'b0, 22'h8040, 3'd3, e_COH_E);
        check("pre_sync_cmd_error", cmd_error_o, 1'b1);
        check("pre_sync_no_tag_v", bus.tag_mem_v_o, 1'b0);
        check("both_pulses_never", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
